// File: rtl/vga_out_pkg.sv
// vga_out_pkg: shared types/constants for the VGA output stage (fade states, level range, RGB slices).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_out_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_HOLD     = 2'd2,
    ST_FADE_IN  = 2'd3
  } fade_state_e;

  localparam logic [3:0] LEVEL_MAX = 4'd15;
  localparam logic       SYNC_IDLE = 1'b1;

  // {R,G,B} nibble positions inside the 12-bit pixel word
  localparam int RGB_R_HI = 11;
  localparam int RGB_R_LO = 8;
  localparam int RGB_G_HI = 7;
  localparam int RGB_G_LO = 4;
  localparam int RGB_B_HI = 3;
  localparam int RGB_B_LO = 0;

  // Brightness scale: (c * (level+1)) >> 4; level 15 is identity, level 0 gives 0.
  function automatic logic [3:0] scale_chan(input logic [3:0] c, input logic [3:0] level);
    logic [4:0] mult;
    logic [8:0] prod;
    mult = {1'b0, level} + 5'd1;
    prod = {5'd0, c} * {4'd0, mult};
    return prod[7:4];
  endfunction

endpackage

// File: rtl/vga_output_stage_if.sv
// vga_output_stage_if: pixel/timing stream in and DAC pin bundle out.
// Latency: n/a (wiring only).
// Backpressure: none; the master drives every cycle, the slave always accepts.
interface vga_output_stage_if;
  logic [11:0] rgb_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        display_active_in;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        hsync;
  logic        vsync;

  modport master (
    output rgb_in, hsync_in, vsync_in, display_active_in,
    input  red, green, blue, hsync, vsync
  );

  modport slave (
    input  rgb_in, hsync_in, vsync_in, display_active_in,
    output red, green, blue, hsync, vsync
  );
endinterface

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: WIDTH-bit shift register, DEPTH stages, per-bit reset value.
// Latency: DEPTH cycles (DEPTH=0 is a wire).
// Backpressure: none; shifts every cycle.
module vga_sync_delay #(
  parameter int                WIDTH   = 3,
  parameter int                DEPTH   = 2,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_ok;
      assign unused_ok = clk ^ reset;
      assign dout      = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      // next stage contents: new sample enters stage 0, everything else moves up one
      always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      // stage registers, reset to the inactive timing values
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= RST_VAL;
          end
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
          end
        end
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_output_stage.sv
// vga_output_stage: aligns syncs to renderer latency, blanks/scales RGB, fades across mode switches (VGA_OUT_FADE_EN).
// Latency: hsync/vsync SYNC_DELAY+1 cycles after input; rgb 1 cycle after rgb_in.
// Backpressure: none; free-running pixel stream, every cycle is consumed.
module vga_output_stage
  import vga_out_pkg::*;
#(
  parameter int SYNC_DELAY       = 2,
  parameter int FADE_STEP_FRAMES = 2
) (
  input  logic              video_clk,
  input  logic              reset,
  vga_output_stage_if.slave vif,
  input  logic              mode_request,
  output logic              display_mode,
  output logic              fade_busy
);

  logic [2:0]  tim_in;
  logic [2:0]  tim_dly;
  logic        act_d;
  logic        frame_tick;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        vsync_prev_q, vsync_prev_d;
  logic [11:0] rgb_q, rgb_d;
  logic        display_mode_q, display_mode_d;
  logic        fade_busy_q, fade_busy_d;

  // bit order {active, vsync, hsync}; syncs idle high, active idles low
  assign tim_in = {vif.display_active_in, vif.vsync_in, vif.hsync_in};

  vga_sync_delay #(
    .WIDTH   (3),
    .DEPTH   (SYNC_DELAY),
    .RST_VAL ({1'b0, SYNC_IDLE, SYNC_IDLE})
  ) u_sync_delay (
    .clk   (video_clk),
    .reset (reset),
    .din   (tim_in),
    .dout  (tim_dly)
  );

  assign act_d      = tim_dly[2];
  // frame tick: falling edge of the undelayed vsync
  assign frame_tick = ~vif.vsync_in & vsync_prev_q;

`ifdef VGA_OUT_FADE_EN
  localparam logic [3:0] STEP_LAST = 4'(FADE_STEP_FRAMES - 1);

  fade_state_e state_q, state_d;
  logic [3:0]  level_q, level_d;
  logic [3:0]  step_q, step_d;
  logic [3:0]  level_dn, level_up;

  // saturating neighbours of the current level
  assign level_dn = (level_q == 4'd0)      ? 4'd0      : level_q - 4'd1;
  assign level_up = (level_q == LEVEL_MAX) ? LEVEL_MAX : level_q + 4'd1;
`endif

  // pixel path next values: delayed syncs, blanked and scaled colour
  always_comb begin
    hsync_d      = tim_dly[0];
    vsync_d      = tim_dly[1];
    vsync_prev_d = vif.vsync_in;
    rgb_d        = '0;
    if (act_d) begin
`ifdef VGA_OUT_FADE_EN
      rgb_d = {scale_chan(vif.rgb_in[RGB_R_HI:RGB_R_LO], level_q),
               scale_chan(vif.rgb_in[RGB_G_HI:RGB_G_LO], level_q),
               scale_chan(vif.rgb_in[RGB_B_HI:RGB_B_LO], level_q)};
`else
      rgb_d = vif.rgb_in;
`endif
    end
  end

  // pixel path output registers
  always_ff @(posedge video_clk) begin
    if (reset) begin
      hsync_q      <= SYNC_IDLE;
      vsync_q      <= SYNC_IDLE;
      vsync_prev_q <= SYNC_IDLE;
      rgb_q        <= '0;
    end else begin
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      vsync_prev_q <= vsync_prev_d;
      rgb_q        <= rgb_d;
    end
  end

`ifdef VGA_OUT_FADE_EN
  // fade FSM next state: request mismatch checks every cycle, level steps only on frame ticks
  always_comb begin
    state_d        = state_q;
    level_d        = level_q;
    step_d         = step_q;
    display_mode_d = display_mode_q;
    case (state_q)
      ST_IDLE: begin
        if (mode_request != display_mode_q) begin
          state_d = ST_FADE_OUT;
          step_d  = '0;
        end
      end
      ST_FADE_OUT: begin
        if (mode_request == display_mode_q) begin
          state_d = ST_FADE_IN;
          step_d  = '0;
        end else if (frame_tick) begin
          if (step_q == STEP_LAST) begin
            step_d  = '0;
            level_d = level_dn;
            // screen is black: safe to flip the mux
            if (level_dn == 4'd0) begin
              display_mode_d = mode_request;
              state_d        = ST_HOLD;
            end
          end else begin
            step_d = step_q + 4'd1;
          end
        end
      end
      ST_HOLD: begin
        // one full tick at black so the new mode settles before showing
        if (frame_tick) begin
          state_d = ST_FADE_IN;
          step_d  = '0;
        end
      end
      ST_FADE_IN: begin
        if (mode_request != display_mode_q) begin
          state_d = ST_FADE_OUT;
          step_d  = '0;
        end else if (frame_tick) begin
          if (step_q == STEP_LAST) begin
            step_d  = '0;
            level_d = level_up;
            if (level_up == LEVEL_MAX) begin
              state_d = ST_IDLE;
            end
          end else begin
            step_d = step_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    fade_busy_d = (state_d != ST_IDLE);
  end

  // fade FSM registers
  always_ff @(posedge video_clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      level_q        <= LEVEL_MAX;
      step_q         <= '0;
      display_mode_q <= 1'b0;
      fade_busy_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      level_q        <= level_d;
      step_q         <= step_d;
      display_mode_q <= display_mode_d;
      fade_busy_q    <= fade_busy_d;
    end
  end
`else
  // no fade: the mux flips on the first frame tick after a request mismatch
  always_comb begin
    display_mode_d = frame_tick ? mode_request : display_mode_q;
    fade_busy_d    = (mode_request != display_mode_d);
  end

  // mode registers
  always_ff @(posedge video_clk) begin
    if (reset) begin
      display_mode_q <= 1'b0;
      fade_busy_q    <= 1'b0;
    end else begin
      display_mode_q <= display_mode_d;
      fade_busy_q    <= fade_busy_d;
    end
  end
`endif

  assign vif.red      = rgb_q[RGB_R_HI:RGB_R_LO];
  assign vif.green    = rgb_q[RGB_G_HI:RGB_G_LO];
  assign vif.blue     = rgb_q[RGB_B_HI:RGB_B_LO];
  assign vif.hsync    = hsync_q;
  assign vif.vsync    = vsync_q;
  assign display_mode = display_mode_q;
  assign fade_busy    = fade_busy_q;

endmodule

// File: tb/tb_vga_output_stage.sv
// tb_vga_output_stage: drives small synthetic frames into vga_output_stage and compares every output cycle.
// Latency: expected values queued one cycle ahead of the DUT register outputs.
// Backpressure: none.
module tb_vga_output_stage;

  localparam int SD        = 2;
  localparam int FSF       = 2;
  localparam int FRAME_LEN = 16;
`ifdef VGA_OUT_FADE_EN
  localparam logic FLIP_AT_TICK = 1'b0;
`else
  localparam logic FLIP_AT_TICK = 1'b1;
`endif

  logic video_clk = 1'b0;
  logic reset;
  logic mode_request;
  logic display_mode;
  logic fade_busy;

  vga_output_stage_if vif();

  vga_output_stage #(
    .SYNC_DELAY       (SD),
    .FADE_STEP_FRAMES (FSF)
  ) dut (
    .video_clk    (video_clk),
    .reset        (reset),
    .vif          (vif),
    .mode_request (mode_request),
    .display_mode (display_mode),
    .fade_busy    (fade_busy)
  );

  always #5 video_clk = ~video_clk;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        mode;
    logic        busy;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  logic [2:0] m_dly[$];
  logic       m_vprev;
  logic [11:0] m_rgb;
  logic       m_hs, m_vs, m_mode, m_busy;
  int         m_level, m_state, m_cnt;

  function automatic logic [3:0] m_scale(input logic [3:0] c, input int lvl);
    int p;
    p = (int'(c) * (lvl + 1)) / 16;
    return p[3:0];
  endfunction

  task automatic model_step();
    exp_t       e;
    logic [2:0] smp, dout;
    logic       tick;
    if (reset) begin
      m_dly.delete();
      for (int i = 0; i < SD; i++) m_dly.push_back(3'b011);
      m_vprev = 1'b1; m_rgb = '0; m_hs = 1'b1; m_vs = 1'b1;
      m_mode = 1'b0; m_busy = 1'b0; m_level = 15; m_state = 0; m_cnt = 0;
    end else begin
      smp = {vif.display_active_in, vif.vsync_in, vif.hsync_in};
      m_dly.push_back(smp);
      dout = m_dly.pop_front();
      tick = !vif.vsync_in && m_vprev;
      m_vprev = vif.vsync_in;
      m_hs = dout[0];
      m_vs = dout[1];
      if (dout[2])
        m_rgb = {m_scale(vif.rgb_in[11:8], m_level), m_scale(vif.rgb_in[7:4], m_level),
                 m_scale(vif.rgb_in[3:0], m_level)};
      else
        m_rgb = '0;
`ifdef VGA_OUT_FADE_EN
      case (m_state)
        0: if (mode_request != m_mode) begin m_state = 1; m_cnt = 0; end
        1: begin
          if (mode_request == m_mode) begin
            m_state = 3; m_cnt = 0;
          end else if (tick) begin
            m_cnt++;
            if (m_cnt == FSF) begin
              m_cnt = 0;
              if (m_level > 0) m_level--;
              if (m_level == 0) begin m_mode = mode_request; m_state = 2; end
            end
          end
        end
        2: if (tick) begin m_state = 3; m_cnt = 0; end
        default: begin
          if (mode_request != m_mode) begin
            m_state = 1; m_cnt = 0;
          end else if (tick) begin
            m_cnt++;
            if (m_cnt == FSF) begin
              m_cnt = 0;
              if (m_level < 15) m_level++;
              if (m_level == 15) m_state = 0;
            end
          end
        end
      endcase
      m_busy = (m_state != 0);
`else
      if (tick) m_mode = mode_request;
      m_busy = (mode_request != m_mode);
`endif
    end
    e.rgb = m_rgb; e.hs = m_hs; e.vs = m_vs; e.mode = m_mode; e.busy = m_busy;
    sb_q.push_back(e);
  endtask

  // one clock: queue the expectation for the inputs now on the pins, then compare after the edge
  task automatic step_cycle();
    exp_t e;
    model_step();
    @(posedge video_clk);
    #1;
    e = sb_q.pop_front();
    check_val("sb_rgb",   12'({vif.red, vif.green, vif.blue}), e.rgb);
    check_val("sb_hsync", 12'(vif.hsync),  12'(e.hs));
    check_val("sb_vsync", 12'(vif.vsync),  12'(e.vs));
    check_val("sb_mode",  12'(display_mode), 12'(e.mode));
    check_val("sb_busy",  12'(fade_busy),  12'(e.busy));
  endtask

  // tiny frames: vsync low for 2 cycles, hsync every 4, active area with per-line blanking
  task automatic run_frames(input int n, input bit rand_pix, input bit glitch);
    for (int f = 0; f < n; f++) begin
      for (int c = 0; c < FRAME_LEN; c++) begin
        vif.vsync_in          = (c >= 2);
        vif.hsync_in          = ((c % 4) != 0);
        vif.display_active_in = (c >= 4) && ((c % 4) != 3);
        vif.rgb_in            = rand_pix ? 12'($urandom) : 12'hFFF;
        if (glitch && f == 1 && (c == 6 || c == 9)) mode_request = ~mode_request;
        step_cycle();
      end
    end
  endtask

  initial begin
    // reset with random inputs
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vif.rgb_in            = 12'($urandom);
      vif.hsync_in          = 1'($urandom);
      vif.vsync_in          = 1'($urandom);
      vif.display_active_in = 1'($urandom);
      mode_request          = 1'($urandom);
      step_cycle();
    end
    check_val("rst_rgb",   12'({vif.red, vif.green, vif.blue}), 12'h000);
    check_val("rst_hsync", 12'(vif.hsync), 12'h1);
    check_val("rst_vsync", 12'(vif.vsync), 12'h1);
    check_val("rst_mode",  12'(display_mode), 12'h0);
    check_val("rst_busy",  12'(fade_busy), 12'h0);

    reset = 1'b0;
    vif.rgb_in = '0; vif.hsync_in = 1'b1; vif.vsync_in = 1'b1;
    vif.display_active_in = 1'b0; mode_request = 1'b0;
    for (int i = 0; i < 4; i++) step_cycle();

    // hsync latency SD+1
    vif.hsync_in = 1'b0;
    step_cycle(); check_val("hs_lat0", 12'(vif.hsync), 12'h1);
    vif.hsync_in = 1'b1;
    step_cycle(); check_val("hs_lat1", 12'(vif.hsync), 12'h1);
    step_cycle(); check_val("hs_lat2", 12'(vif.hsync), 12'h0);
    step_cycle(); check_val("hs_lat3", 12'(vif.hsync), 12'h1);

    // active pixel F84 at full brightness
    vif.display_active_in = 1'b1;
    step_cycle();
    step_cycle();
    vif.rgb_in = 12'hF84;
    step_cycle();
    check_val("px_red",   12'(vif.red),   12'hF);
    check_val("px_green", 12'(vif.green), 12'h8);
    check_val("px_blue",  12'(vif.blue),  12'h4);

    // blanking: white in, black out once the delayed active flag drops
    vif.rgb_in = 12'hFFF;
    vif.display_active_in = 1'b0;
    step_cycle();
    step_cycle();
    for (int i = 0; i < 6; i++) begin
      step_cycle();
      check_val("blank_rgb", 12'({vif.red, vif.green, vif.blue}), 12'h000);
    end

    // text -> graphics switch, white frames so every fade level shows up
    mode_request = 1'b1;
    run_frames(70, 1'b0, 1'b0);
    check_val("sw_mode", 12'(display_mode), 12'h1);
    check_val("sw_busy", 12'(fade_busy), 12'h0);

    // short request glitch inside one frame
    run_frames(4, 1'b1, 1'b1);

    // request flips away and comes back mid-fade
    mode_request = 1'b0;
    run_frames(8, 1'b1, 1'b0);
    mode_request = 1'b1;
    run_frames(20, 1'b1, 1'b0);
    check_val("rev_mode", 12'(display_mode), 12'h1);
    check_val("rev_busy", 12'(fade_busy), 12'h0);

    // reset in the middle of a fade
    mode_request = 1'b0;
    run_frames(10, 1'b1, 1'b0);
    reset = 1'b1;
    step_cycle();
    reset = 1'b0;
    check_val("mrst_mode", 12'(display_mode), 12'h0);
    check_val("mrst_busy", 12'(fade_busy), 12'h0);
    check_val("mrst_rgb",  12'({vif.red, vif.green, vif.blue}), 12'h000);

    // fresh request after reset; flip (if unfaded) lands exactly on the next tick
    vif.vsync_in = 1'b1; vif.hsync_in = 1'b1; vif.display_active_in = 1'b0;
    mode_request = 1'b1;
    step_cycle();
    check_val("post_busy", 12'(fade_busy), 12'h1);
    step_cycle();
    step_cycle();
    check_val("pre_tick_mode", 12'(display_mode), 12'h0);
    vif.vsync_in = 1'b0;
    step_cycle();
    check_val("tick_mode", 12'(display_mode), 12'(FLIP_AT_TICK));
    run_frames(3, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
